// File: rtl/dds_cmd_ctrl.sv
// Command-stream controller for the multi-table DDS core: shadow/active
// frequency and phase registers, table selection and table-reload sequencing.
//
// state      | meaning
// S_IDLE     | decode command headers
// S_FREQ_PL  | wait for the SET_FREQ payload word
// S_LD_SETUP | one dead cycle, wr_enable low, so the DDS rebases its write address
// S_LD_DATA  | stream 2**HR table words to the DDS RAM
// S_LD_END   | final write strobe and load_done pulse
module dds_cmd_ctrl #(
  parameter int HORIZON_RESOLUTION = 12,
  parameter int ADDER_LOWBIT       = 20,
  parameter int WAVE_STORE         = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_data,
  output logic [WAVE_STORE-1:0]    wave_sel,
  output logic [(2**WAVE_STORE)*(HORIZON_RESOLUTION+ADDER_LOWBIT)-1:0] freq_ctrl,
  output logic [(2**WAVE_STORE)*HORIZON_RESOLUTION-1:0]                phase_ctrl,
  output logic                     wr_enable,
  output logic                     wr_valid,
  output logic [31:0]              wr_data,
  output logic                     busy,
  output logic                     load_done,
  output logic                     cmd_err
);

  localparam int HR    = HORIZON_RESOLUTION;
  localparam int FW    = HORIZON_RESOLUTION + ADDER_LOWBIT;
  localparam int NT    = 2 ** WAVE_STORE;
  localparam int CNT_W = HR + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'((2 ** HR) - 1);

  localparam logic [3:0] OP_SET_FREQ  = 4'h1;
  localparam logic [3:0] OP_SET_PHASE = 4'h2;
  localparam logic [3:0] OP_APPLY     = 4'h3;
  localparam logic [3:0] OP_SELECT    = 4'h4;
  localparam logic [3:0] OP_LOAD      = 4'h5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREQ_PL,
    S_LD_SETUP,
    S_LD_DATA,
    S_LD_END
  } state_t;

  state_t state, state_nxt;

  logic [FW-1:0]         shadow_freq  [NT];
  logic [HR-1:0]         shadow_phase [NT];
  logic [WAVE_STORE-1:0] disp_sel;
  logic [WAVE_STORE-1:0] hdr_ch;
  logic [CNT_W-1:0]      word_cnt;

  logic [3:0]            op;
  logic [WAVE_STORE-1:0] ch;
  logic [HR-1:0]         arg;
  logic                  xfer;

  assign op   = cmd_data[31:28];
  assign ch   = cmd_data[24 +: WAVE_STORE];
  assign arg  = cmd_data[HR-1:0];
  assign cmd_ready = (state == S_IDLE) || (state == S_FREQ_PL) || (state == S_LD_DATA);
  assign xfer = cmd_valid && cmd_ready;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_enable = 1'b0;
    load_done = 1'b0;
    wave_sel  = disp_sel;
    case (state)
      S_IDLE: begin
        if (xfer && op == OP_SET_FREQ) state_nxt = S_FREQ_PL;
        if (xfer && op == OP_LOAD)     state_nxt = S_LD_SETUP;
      end
      S_FREQ_PL: begin
        if (xfer) state_nxt = S_IDLE;
      end
      S_LD_SETUP: begin
        wave_sel  = hdr_ch;
        state_nxt = S_LD_DATA;
      end
      S_LD_DATA: begin
        wave_sel  = hdr_ch;
        wr_enable = 1'b1;
        if (xfer && word_cnt == LAST_WORD) state_nxt = S_LD_END;
      end
      S_LD_END: begin
        wave_sel  = hdr_ch;
        wr_enable = 1'b1;
        load_done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NT; i++) begin
        shadow_freq[i]  <= '0;
        shadow_phase[i] <= '0;
      end
      freq_ctrl  <= '0;
      phase_ctrl <= '0;
      disp_sel   <= '0;
      hdr_ch     <= '0;
      word_cnt   <= '0;
      wr_valid   <= 1'b0;
      wr_data    <= '0;
      cmd_err    <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      cmd_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            case (op)
              OP_SET_FREQ:  hdr_ch <= ch;
              OP_SET_PHASE: shadow_phase[ch] <= arg;
              OP_APPLY: begin
                // all tables commit on the same edge
                for (int i = 0; i < NT; i++) begin
                  freq_ctrl[i*FW +: FW]  <= shadow_freq[i];
                  phase_ctrl[i*HR +: HR] <= shadow_phase[i];
                end
              end
              OP_SELECT:    disp_sel <= ch;
              OP_LOAD:      hdr_ch <= ch;
              default:      cmd_err <= 1'b1;
            endcase
          end
        end
        S_FREQ_PL: begin
          if (xfer) shadow_freq[hdr_ch] <= cmd_data[FW-1:0];
        end
        S_LD_SETUP: word_cnt <= '0;
        S_LD_DATA: begin
          if (xfer) begin
            wr_valid <= 1'b1;
            wr_data  <= cmd_data;
            word_cnt <= word_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
